// File: rtl/rv_multicycle_control.sv
// Multicycle control FSM for an RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and resolves branches
// from the ALU result it requested (sub of rs1, rs2).
module rv_multicycle_control #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic [31:0] alu_out,
    input  logic        alu_msb,
    output logic [2:0]  alu_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        target_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_addr_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal
);
    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    state_t      state, state_nxt;
    logic [3:0]  hold_cnt;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [2:0]  r_sel, i_sel;
    logic        r_ok, i_ok, taken;
    logic        unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices are consumed by the datapath, not by control.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // State register; reset forces START, which also kills memory strobes at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_START;
        else        state <= state_nxt;
    end

    // Counts cycles spent in START after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                hold_cnt <= 4'd0;
        else if (state == S_START) hold_cnt <= hold_cnt + 4'd1;
        else                       hold_cnt <= 4'd0;
    end

    // ALU op lookup for register and immediate arithmetic forms.
    always_comb begin
        r_sel = 3'd7;
        r_ok  = 1'b1;
        i_sel = 3'd7;
        i_ok  = 1'b1;
        case ({funct7, funct3})
            {7'b0000000, 3'b000}: r_sel = 3'd0;
            {7'b0100000, 3'b000}: r_sel = 3'd5;
            {7'b0000000, 3'b111}: r_sel = 3'd1;
            {7'b0000000, 3'b100}: r_sel = 3'd2;
            {7'b0000000, 3'b001}: r_sel = 3'd3;
            {7'b0100000, 3'b101}: r_sel = 3'd4;
            default:              r_ok  = 1'b0;
        endcase
        case (funct3)
            3'b000:  i_sel = 3'd0;
            3'b111:  i_sel = 3'd1;
            3'b100:  i_sel = 3'd2;
            3'b001:  if (funct7 == 7'b0000000) i_sel = 3'd3; else i_ok = 1'b0;
            3'b101:  if (funct7 == 7'b0100000) i_sel = 3'd4; else i_ok = 1'b0;
            default: i_ok = 1'b0;
        endcase
    end

    // Branch decision from rs1-rs2; signed overflow deliberately ignored.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (alu_out == 32'd0);
            3'b001:  taken = (alu_out != 32'd0);
            3'b100:  taken = alu_msb;
            3'b101:  taken = !alu_msb;
            default: taken = 1'b0;
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt    = state;
        alu_sel      = 3'd7;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        imm_sel      = 2'd0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        target_write = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        illegal      = 1'b0;
        case (state)
            S_START: if (hold_cnt == HOLD_LAST) state_nxt = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd2;
                alu_sel   = 3'd0;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a    = 2'd2;
                alu_src_b    = 2'd1;
                alu_sel      = 3'd0;
                target_write = 1'b1;
                if (opcode == OP_BRANCH)   imm_sel = 2'd2;
                else if (opcode == OP_JAL) imm_sel = 2'd3;
                case (opcode)
                    OP_R:      state_nxt = S_EXEC_R;
                    OP_I:      state_nxt = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  state_nxt = (funct3 == 3'b010) ? S_MEM_ADDR : S_ILLEGAL;
                    OP_BRANCH: state_nxt = (funct3 == 3'b000 || funct3 == 3'b001 ||
                                            funct3 == 3'b100 || funct3 == 3'b101)
                                           ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:    state_nxt = S_JAL;
                    OP_JALR:   state_nxt = (funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
                    default:   state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_sel   = r_sel;
                state_nxt = r_ok ? S_WB_ALU : S_ILLEGAL;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_sel   = i_sel;
                state_nxt = i_ok ? S_WB_ALU : S_ILLEGAL;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_sel   = 3'd0;
                imm_sel   = (opcode == OP_STORE) ? 2'd1 : 2'd0;
                state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read     = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) state_nxt = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
                state_nxt = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write    = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_sel   = 3'd5;
                pc_write  = taken;
                pc_src    = taken;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_sel   = 3'd6;
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   state_nxt = S_START;
        endcase
    end
endmodule

// File: tb/tb_rv_multicycle_control.sv
// Bench for rv_multicycle_control: stimulus pushes per-cycle expected
// control words into a queue; a negedge monitor pops and compares.
module tb_rv_multicycle_control;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, alu_out;
    logic        mem_ready, alu_msb;
    logic [2:0]  alu_sel;
    logic [1:0]  alu_src_a, alu_src_b, imm_sel, wb_sel;
    logic        ir_write, pc_write, pc_src, target_write, mem_read, mem_write;
    logic        mem_addr_sel, reg_write, illegal;

    rv_multicycle_control #(.RESET_PC_HOLD(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .alu_out(alu_out), .alu_msb(alu_msb), .alu_sel(alu_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .target_write(target_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr_sel(mem_addr_sel), .reg_write(reg_write), .wb_sel(wb_sel),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] a, b, imm;
        logic irw, pcw, pcs, tw, mrd, mwr, mas, rw;
        logic [1:0] wb;
        logic ill;
    } ov_t;

    typedef struct {
        ov_t   exp;
        ov_t   care;
        string tag;
    } sb_t;

    sb_t  q[$];
    sb_t  mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    ov_t  act;
    ov_t  all_care;

    assign act = {alu_sel, alu_src_a, alu_src_b, imm_sel, ir_write, pc_write, pc_src,
                  target_write, mem_read, mem_write, mem_addr_sel, reg_write, wb_sel, illegal};

    function automatic ov_t mk(int sel, int a, int b, int imm, int irw, int pcw, int pcs,
                               int tw, int mrd, int mwr, int mas, int rw, int wb, int ill);
        ov_t r;
        r.sel = 3'(sel); r.a = 2'(a); r.b = 2'(b); r.imm = 2'(imm);
        r.irw = 1'(irw); r.pcw = 1'(pcw); r.pcs = 1'(pcs); r.tw = 1'(tw);
        r.mrd = 1'(mrd); r.mwr = 1'(mwr); r.mas = 1'(mas); r.rw = 1'(rw);
        r.wb = 2'(wb); r.ill = 1'(ill);
        return r;
    endfunction

    // Monitor: the DUT presents a control word every cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            vectors++;
            if (((act ^ mon_e.exp) & mon_e.care) != '0) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h (care %h) at %0t",
                         mon_e.tag, act, mon_e.exp, mon_e.care, $time);
            end
        end
    end

    task automatic step(input ov_t x, input ov_t c, input string tag,
                        input int mr, input logic [31:0] ao, input int am);
        sb_t s;
        mem_ready = 1'(mr);
        alu_out   = ao;
        alu_msb   = 1'(am);
        s.exp = x; s.care = c; s.tag = tag;
        q.push_back(s);
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic fetch_decode(input logic [31:0] iw, input int fw);
        int imm;
        instr = iw;
        imm = (iw[6:0] == 7'b1100011) ? 2 : (iw[6:0] == 7'b1101111) ? 3 : 0;
        for (int i = 0; i < fw; i++)
            step(mk(0,0,2,0, 0,0,0,0, 1,0,0,0, 0,0), all_care, "fetch_wait", 0, $urandom, 1);
        step(mk(0,0,2,0, 1,1,0,0, 1,0,0,0, 0,0), all_care, "fetch", 1, $urandom, 0);
        step(mk(0,2,1,imm, 0,0,0,1, 0,0,0,0, 0,0), all_care, "decode", 1, $urandom, 1);
    endtask

    // Reference: expected cycle-by-cycle control for one legal instruction.
    task automatic run(input logic [31:0] iw, input int xsel, input int fw, input int mw,
                       input logic [31:0] bao, input int bam);
        int  tk;
        ov_t c;
        fetch_decode(iw, fw);
        case (iw[6:0])
            7'b0110011: begin
                step(mk(xsel,1,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "exec_r", 1, $urandom, 0);
                step(mk(7,0,0,0, 0,0,0,0, 0,0,0,1, 0,0), all_care, "wb_alu", 1, $urandom, 1);
            end
            7'b0010011: begin
                step(mk(xsel,1,1,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "exec_i", 1, $urandom, 0);
                step(mk(7,0,0,0, 0,0,0,0, 0,0,0,1, 0,0), all_care, "wb_alu", 1, $urandom, 1);
            end
            7'b0000011: begin
                step(mk(0,1,1,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "ld_addr", 1, $urandom, 0);
                for (int i = 0; i < mw; i++)
                    step(mk(7,0,0,0, 0,0,0,0, 1,0,1,0, 0,0), all_care, "mem_rd_wait", 0, $urandom, 0);
                step(mk(7,0,0,0, 0,0,0,0, 1,0,1,0, 0,0), all_care, "mem_rd", 1, $urandom, 0);
                step(mk(7,0,0,0, 0,0,0,0, 0,0,0,1, 1,0), all_care, "wb_mem", 1, $urandom, 1);
            end
            7'b0100011: begin
                step(mk(0,1,1,1, 0,0,0,0, 0,0,0,0, 0,0), all_care, "st_addr", 1, $urandom, 0);
                for (int i = 0; i < mw; i++)
                    step(mk(7,0,0,0, 0,0,0,0, 0,1,1,0, 0,0), all_care, "mem_wr_wait", 0, $urandom, 0);
                step(mk(7,0,0,0, 0,0,0,0, 0,1,1,0, 0,0), all_care, "mem_wr", 1, $urandom, 0);
            end
            7'b1100011: begin
                case (iw[14:12])
                    3'b000:  tk = (bao == 0) ? 1 : 0;
                    3'b001:  tk = (bao != 0) ? 1 : 0;
                    3'b100:  tk = bam;
                    default: tk = 1 - bam;
                endcase
                c = all_care;
                if (tk == 0) c.pcs = 1'b0;
                step(mk(5,1,0,0, 0,tk,tk,0, 0,0,0,0, 0,0), c, "branch", 1, bao, bam);
            end
            7'b1101111:
                step(mk(7,0,0,0, 0,1,1,0, 0,0,0,1, 2,0), all_care, "jal", 1, $urandom, 0);
            default:
                step(mk(6,1,1,0, 0,1,0,0, 0,0,0,1, 2,0), all_care, "jalr", 1, $urandom, 1);
        endcase
    endtask

    // Illegal encodings: optional execute cycle, then a sticky ILLEGAL, then reset.
    task automatic run_illegal(input logic [31:0] iw, input int has_exec);
        ov_t c;
        fetch_decode(iw, 0);
        if (has_exec != 0) begin
            c = all_care;
            c.sel = '0; c.a = '0; c.b = '0; c.imm = '0;
            step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), c, "exec_bad", 1, $urandom, 0);
        end
        for (int i = 0; i < 4; i++)
            step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,1), all_care, "illegal_hold", 1, $urandom, i % 2);
        #2 rst_n = 1'b0; #1;
        chk("illegal_async_clear", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;
        step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "in_reset", 1, $urandom, 0);
        rst_n = 1'b1;
        step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "start", 1, $urandom, 0);
    endtask

    // Random legal instruction together with its expected ALU op.
    task automatic gen(output logic [31:0] iw, output int xsel);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] im;
        logic [2:0]  f3;
        int k, j;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); im = 12'($urandom);
        k = $urandom_range(6); j = $urandom_range(5);
        xsel = 7;
        case (k)
            0: case (j)
                0: begin iw = {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011}; xsel = 0; end
                1: begin iw = {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011}; xsel = 5; end
                2: begin iw = {7'h00, rs2, rs1, 3'b111, rd, 7'b0110011}; xsel = 1; end
                3: begin iw = {7'h00, rs2, rs1, 3'b100, rd, 7'b0110011}; xsel = 2; end
                4: begin iw = {7'h00, rs2, rs1, 3'b001, rd, 7'b0110011}; xsel = 3; end
                default: begin iw = {7'h20, rs2, rs1, 3'b101, rd, 7'b0110011}; xsel = 4; end
            endcase
            1: case (j)
                0: begin iw = {im, rs1, 3'b000, rd, 7'b0010011}; xsel = 0; end
                1: begin iw = {im, rs1, 3'b111, rd, 7'b0010011}; xsel = 1; end
                2: begin iw = {im, rs1, 3'b100, rd, 7'b0010011}; xsel = 2; end
                3: begin iw = {7'h00, rs2, rs1, 3'b001, rd, 7'b0010011}; xsel = 3; end
                default: begin iw = {7'h20, rs2, rs1, 3'b101, rd, 7'b0010011}; xsel = 4; end
            endcase
            2: iw = {im, rs1, 3'b010, rd, 7'b0000011};
            3: iw = {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
            4: begin
                case (j % 4)
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
                iw = {im[11:5], rs2, rs1, f3, im[4:0], 7'b1100011};
            end
            5: iw = {im, rs1, rs2[2:0], rd, 7'b1101111};
            default: iw = {im, rs1, 3'b000, rd, 7'b1100111};
        endcase
    endtask

    initial begin
        logic [31:0] iw;
        int          xs;
        all_care = '1;
        rst_n = 1'b0; instr = '0; mem_ready = 1'b0; alu_out = '0; alu_msb = 1'b0;
        @(posedge clk); #1;
        step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "reset", 1, 32'd0, 0);
        step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "reset", 1, 32'd0, 0);
        rst_n = 1'b1;
        step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "start", 1, 32'd0, 0);

        run(32'h40208133, 5, 0, 0, 32'd1, 0);             // sub
        run(32'h0040A103, 0, 1, 2, 32'd1, 0);             // lw, 2 wait cycles
        run(32'h0020C463, 0, 0, 0, 32'h8000_0000, 1);     // blt taken
        run(32'h0020C463, 0, 0, 0, 32'h0000_0005, 0);     // blt not taken
        run(32'h00208463, 0, 0, 0, 32'd0, 1);             // beq taken
        run(32'h00209463, 0, 0, 0, 32'd0, 0);             // bne not taken
        run(32'h000080E7, 6, 0, 0, 32'd1, 0);             // jalr

        for (int n = 0; n < 250; n++) begin
            gen(iw, xs);
            run(iw, xs, $urandom_range(2), $urandom_range(3),
                ($urandom_range(1) == 1) ? 32'd0 : ($urandom | 32'd1), $urandom_range(1));
        end

        // Reset while a store is waiting on memory.
        fetch_decode(32'h0020A223, 0);
        step(mk(0,1,1,1, 0,0,0,0, 0,0,0,0, 0,0), all_care, "st_addr", 1, 32'd0, 0);
        step(mk(7,0,0,0, 0,0,0,0, 0,1,1,0, 0,0), all_care, "mem_wr_wait", 0, 32'd0, 0);
        chk("mem_write_before_reset", {31'd0, mem_write}, 32'd1);
        #2 rst_n = 1'b0; #1;
        chk("async_strobe_drop", {30'd0, mem_write, mem_read}, 32'd0);
        @(posedge clk); #1;
        step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "in_reset", 0, 32'd0, 0);
        rst_n = 1'b1;
        step(mk(7,0,0,0, 0,0,0,0, 0,0,0,0, 0,0), all_care, "start", 0, 32'd0, 0);
        run(32'h00310233, 0, 0, 0, 32'd1, 0);             // add after reset

        run_illegal(32'h20005093, 1);                     // srai with funct7 0x10
        run_illegal(32'h0000007F, 0);                     // unknown opcode
        run_illegal(32'h02000033, 1);                     // R-type funct7 0x01
        run(32'h0040006F, 0, 0, 0, 32'd1, 0);             // jal after recovery

        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected words left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
